alu_bist_driver: RTL
====================

// Module: alu_bist_driver
// PURPOSE
//   Initiator side of the 4-bit ALU operand/opcode interface. On start it drives every
//   enabled opcode with all 256 {a,b} nibble pairs, one vector per cycle, into the ALU.
//   It compares each returned result against an internal reference model after a fixed
//   latency. It reports done/pass, a saturating error count and the first failing vector.
//   It sits beside the ALU as an on-chip self-test and bring-up block.
// PARAMETERS
//   OP_MASK  8'h3F  bit n=1 -> opcode n exercised (ops 0..7, ascending order)
//   LATENCY  1      ALU result latency in cycles, legal range 1..4
// PORTS
//   clk         in   1   clock, all state on rising edge
//   rst_n       in   1   asynchronous active-low reset
//   start       in   1   level-sampled request to begin a run
//   alu_a       out  4   operand a (ALU zero-extends to 8 bits)
//   alu_b       out  4   operand b (ALU zero-extends to 8 bits)
//   alu_op      out  3   opcode
//   alu_result  in   8   ALU result, valid LATENCY cycles after its vector
//   busy        out  1   run in progress (RUN or DRAIN)
//   done        out  1   run complete; held until next start or reset
//   pass        out  1   done && err_count==0
//   err_count   out  8   mismatches this run, saturates at 255
//   fail_vec    out  11  {op,a,b} of the first mismatch; 0 if none
// BEHAVIOUR
//   Reset: state=IDLE; every output and internal register is 0. Entry is immediate (async).
//   FSM: IDLE -start-> RUN; RUN -last vector issued-> DRAIN;
//        DRAIN -LATENCY cycles-> DONE; DONE -start-> RUN (restart).
//   start is ignored in RUN and DRAIN.
//   Entry to RUN clears err_count, fail_vec and done.
//   OP_MASK==0: start moves IDLE->DONE in one edge with pass=1.
//   Vector order: op ascends over enabled bits; per op, a 0..15 outer, b 0..15 inner.
//   alu_{op,a,b} change on the edge after each vector's cycle.
//   Timing: start sampled high at edge E0. Vector i is driven during cycle i (edges E0+i..E0+i+1).
//   Vector i is compared at the end of cycle i+LATENCY.
//   N = 256*popcount(OP_MASK). done/pass are valid from edge E0+N+LATENCY onward.
//   busy is high from E0 to that same edge.
//   alu_* read 0 in IDLE, DRAIN and DONE.
//   Expected model (8-bit, A={4'b0,a}, B={4'b0,b}):
//     000 A+B; 001 A-B mod 256 (wraps, e.g. 0-1=8'hFF); 010 A&B; 100 A|B;
//     101 A*B (max 225, no overflow); 011 A/B integer division, compare SKIPPED when b==0;
//     110,111 -> 8'h00.
//   Expected values and vector tags pass through a LATENCY-deep shift register aligned to alu_result.
//   Mismatch: err_count+=1 unless already 255. fail_vec is captured only when err_count was 0.
//   Reset mid-run: async return to IDLE, all outputs 0. No partial results are kept.
// TESTING
//   1 Golden ALU model, LATENCY=1, OP_MASK=8'h3F, pulse start
//     -> busy for 1537 cycles, then done=1, pass=1, err_count=0.
//   2 Force alu_result[0] stuck-at-1 -> err_count=255 (saturated), pass=0,
//     fail_vec=11'h000 (op0, a=0, b=0, expected 0).
//   3 OP_MASK=8'h01, LATENCY=3 -> exactly 256 vectors, op held at 0,
//     done at edge E0+259, pass=1.
//   4 Assert rst_n=0 at vector 700 -> all outputs 0 at once, without a clock edge.
//     Restart -> full clean run, pass=1.
//   5 Hold start high through RUN -> no restart. start in DONE -> new run, err_count cleared.
//   6 ALU returns 8'hFF for op 011 with b=0 -> no errors counted, pass=1.

Source files
------------

// File: rtl/alu_bist_driver.sv
// rtl/alu_bist_driver.sv - built-in self-test initiator for the 4-bit ALU interface.
// Sweeps every enabled opcode over all {a,b} pairs and checks the results against a reference model.
module alu_bist_driver #(
  parameter logic [7:0] OP_MASK = 8'h3F,
  parameter int         LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [3:0]  alu_a,
  output logic [3:0]  alu_b,
  output logic [2:0]  alu_op,
  input  logic [7:0]  alu_result,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  err_count,
  output logic [10:0] fail_vec
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  function automatic logic [2:0] first_op(input logic [7:0] m);
    first_op = 3'd0;
    for (int i = 7; i >= 0; i--) if (m[i]) first_op = 3'(i);
  endfunction

  function automatic logic [2:0] last_op(input logic [7:0] m);
    last_op = 3'd0;
    for (int i = 0; i < 8; i++) if (m[i]) last_op = 3'(i);
  endfunction

  function automatic logic [2:0] next_op(input logic [7:0] m, input logic [2:0] cur);
    logic found;
    next_op = cur;
    found   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!found && i > int'(cur) && m[i]) begin
        next_op = 3'(i);
        found   = 1'b1;
      end
    end
  endfunction

  localparam logic [2:0] FIRST_OP = first_op(OP_MASK);
  localparam logic [2:0] LAST_OP  = last_op(OP_MASK);

  state_t      state, state_nx;
  logic        run_entry, last_vec;
  logic [2:0]  drain_cnt;
  logic [7:0]  exp_nx;
  logic        skip_nx;
  logic [7:0]  A, B;

  logic [LATENCY-1:0] pipe_vld;
  logic [7:0]         pipe_exp [LATENCY];
  logic [10:0]        pipe_tag [LATENCY];

  assign last_vec = (alu_op == LAST_OP) && (alu_a == 4'hF) && (alu_b == 4'hF);
  assign pass     = done && (err_count == 8'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    run_entry = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          run_entry = 1'b1;
          state_nx  = (OP_MASK == 8'h00) ? DONE : RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_vec) state_nx = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_cnt == 3'(LATENCY - 1)) state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Reference model for the vector currently on the bus; divide by zero is not checked.
  always_comb begin
    A       = {4'b0, alu_a};
    B       = {4'b0, alu_b};
    exp_nx  = 8'h00;
    skip_nx = 1'b0;
    case (alu_op)
      3'd0: exp_nx = A + B;
      3'd1: exp_nx = A - B;
      3'd2: exp_nx = A & B;
      3'd3: begin
        if (alu_b == 4'h0) skip_nx = 1'b1;
        else               exp_nx  = A / B;
      end
      3'd4: exp_nx = A | B;
      3'd5: exp_nx = A * B;
      default: exp_nx = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_op    <= 3'd0;
      alu_a     <= 4'd0;
      alu_b     <= 4'd0;
      drain_cnt <= 3'd0;
      done      <= 1'b0;
      err_count <= 8'd0;
      fail_vec  <= 11'd0;
      pipe_vld  <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        pipe_exp[k] <= 8'd0;
        pipe_tag[k] <= 11'd0;
      end
    end else begin
      if (state_nx == RUN) begin
        if (state != RUN) begin
          {alu_op, alu_a, alu_b} <= {FIRST_OP, 4'd0, 4'd0};
        end else begin
          alu_b <= alu_b + 4'd1;
          if (alu_b == 4'hF) begin
            alu_a <= alu_a + 4'd1;
            if (alu_a == 4'hF) alu_op <= next_op(OP_MASK, alu_op);
          end
        end
      end else begin
        {alu_op, alu_a, alu_b} <= 11'd0;
      end

      drain_cnt <= (state == DRAIN) ? drain_cnt + 3'd1 : 3'd0;

      if (run_entry)                               done <= (OP_MASK == 8'h00);
      else if (state == DRAIN && state_nx == DONE) done <= 1'b1;

      if (run_entry) begin
        err_count <= 8'd0;
        fail_vec  <= 11'd0;
      end else if (pipe_vld[LATENCY-1] && (pipe_exp[LATENCY-1] != alu_result)) begin
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        if (err_count == 8'd0)  fail_vec  <= pipe_tag[LATENCY-1];
      end

      pipe_vld[0] <= (state == RUN) && !skip_nx;
      pipe_exp[0] <= exp_nx;
      pipe_tag[0] <= {alu_op, alu_a, alu_b};
      for (int k = 1; k < LATENCY; k++) begin
        pipe_vld[k] <= pipe_vld[k-1];
        pipe_exp[k] <= pipe_exp[k-1];
        pipe_tag[k] <= pipe_tag[k-1];
      end
    end
  end

endmodule
